// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives the PLL reset and qualifies the PLL lock.
// It also staggers the releases of the three output-clock domain resets.
// Failed lock attempts are retried, and a lock loss in RUN is recovered
// by resequencing. Every output is a flop.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3,
    parameter int RELEASE_GAP         = 8,
    parameter int SYNC_STAGES         = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic [2:0] domain_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_count,
    output logic [2:0] state_o
);

    // One shared timer serves as the pulse, timeout, stable and gap counter.
    localparam int TMAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int TMAX_B = (LOCK_TIMEOUT_CYCLES > 2*RELEASE_GAP+1) ? LOCK_TIMEOUT_CYCLES : 2*RELEASE_GAP+1;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int RW     = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] C_PULSE_LAST   = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] C_STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] C_GAP          = TW'(RELEASE_GAP);
    localparam logic [TW-1:0] C_REL_LAST     = TW'(2 * RELEASE_GAP);
    localparam logic [RW-1:0] C_MAX_RETRIES  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_locked_s;
    state_t                 r_state, w_state_n;
    logic [TW-1:0]          r_timer, w_timer_n;
    logic [RW-1:0]          r_retries, w_retries_n, w_retries_inc;
    logic [7:0]             r_relock, w_relock_n;
    logic                   r_pll_rst, w_pll_rst_n;
    logic [2:0]             r_dom, w_dom_n;
    logic                   r_ready, w_ready_n;
    logic                   r_fail, w_fail_n;

    assign w_locked_s    = r_sync[SYNC_STAGES-1];
    assign w_retries_inc = r_retries + 1'b1;

    // Bring the asynchronous lock indication into the refclk domain.
    always_ff @(posedge refclk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end

    // Next-state, timer, retry and relock-count logic; restart overrides all.
    always_comb begin
        w_state_n   = r_state;
        w_timer_n   = r_timer + 1'b1;
        w_retries_n = r_retries;
        w_relock_n  = r_relock;
        if (restart) begin
            w_state_n   = S_RESET_PLL;
            w_timer_n   = '0;
            w_retries_n = '0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == C_PULSE_LAST) begin
                        w_state_n = S_WAIT_LOCK;
                        w_timer_n = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_n = S_STABLE;
                        w_timer_n = '0;
                    end else if (r_timer == C_TIMEOUT_LAST) begin
                        w_retries_n = w_retries_inc;
                        w_state_n   = (w_retries_inc >= C_MAX_RETRIES) ? S_FAIL : S_RESET_PLL;
                        w_timer_n   = '0;
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s) begin
                        w_state_n = S_WAIT_LOCK;
                        w_timer_n = '0;
                    end else if (r_timer == C_STABLE_LAST) begin
                        w_state_n = S_RELEASE;
                        w_timer_n = '0;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (!w_locked_s) begin
                        w_state_n  = S_RESET_PLL;
                        w_timer_n  = '0;
                        w_relock_n = (r_relock == 8'hFF) ? r_relock : r_relock + 8'd1;
                    end else if (r_state == S_RUN) begin
                        w_timer_n = '0;
                    end else if (r_timer == C_REL_LAST) begin
                        w_state_n   = S_RUN;
                        w_timer_n   = '0;
                        w_retries_n = '0;
                    end
                end
                S_FAIL: begin
                    w_timer_n = '0;
                end
                default: begin
                    w_state_n = S_RESET_PLL;
                    w_timer_n = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered outputs line up with state_o.
    always_comb begin
        w_pll_rst_n = 1'b0;
        w_dom_n     = 3'b111;
        w_ready_n   = 1'b0;
        w_fail_n    = 1'b0;
        case (w_state_n)
            S_RESET_PLL: w_pll_rst_n = 1'b1;
            S_RELEASE:   w_dom_n = {w_timer_n < C_REL_LAST, w_timer_n < C_GAP, 1'b0};
            S_RUN: begin
                w_dom_n   = 3'b000;
                w_ready_n = 1'b1;
            end
            S_FAIL: begin
                w_pll_rst_n = 1'b1;
                w_fail_n    = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= S_RESET_PLL;
            r_timer   <= '0;
            r_retries <= '0;
            r_relock  <= '0;
            r_pll_rst <= 1'b1;
            r_dom     <= 3'b111;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_retries <= w_retries_n;
            r_relock  <= w_relock_n;
            r_pll_rst <= w_pll_rst_n;
            r_dom     <= w_dom_n;
            r_ready   <= w_ready_n;
            r_fail    <= w_fail_n;
        end
    end

    assign pll_rst      = r_pll_rst;
    assign domain_rst   = r_dom;
    assign ready        = r_ready;
    assign fail         = r_fail;
    assign relock_count = r_relock;
    assign state_o      = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: stimulus pushes the expected sequence of
// output snapshots (with cycle spacing), a monitor pops one per output change.
module tb_pll_reset_sequencer;

    localparam int RP = 4, LS = 8, TO = 32, MR = 2, G = 2, SS = 2;
    localparam int W_READY = 0, W_FAIL = 1, W_REL = 2, W_PRST_HI = 3, W_PRST_LO = 4;

    logic       refclk = 1'b0;
    logic       rst, pll_locked, restart;
    logic       pll_rst, ready, fail;
    logic [2:0] domain_rst, state_o;
    logic [7:0] relock_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       prst;
        logic [2:0] dom;
        logic       rdy;
        logic       fl;
        logic [7:0] rc;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
    } exp_t;

    exp_t q[$];

    pll_reset_sequencer #(
        .RST_PULSE_CYCLES(RP), .LOCK_STABLE_CYCLES(LS), .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR), .RELEASE_GAP(G), .SYNC_STAGES(SS)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
        .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .fail(fail),
        .relock_count(relock_count), .state_o(state_o)
    );

    always #5 refclk = ~refclk;

    function automatic void push(input logic [2:0] st, input logic prst, input logic [2:0] dom,
                                 input logic rdy, input logic fl, input logic [7:0] rc, input int gap);
        exp_t e;
        e.s.st = st; e.s.prst = prst; e.s.dom = dom; e.s.rdy = rdy; e.s.fl = fl; e.s.rc = rc;
        e.gap = gap;
        q.push_back(e);
    endfunction

    function automatic bit cond(input int which);
        case (which)
            W_READY:   return ready === 1'b1;
            W_FAIL:    return fail === 1'b1;
            W_REL:     return state_o === 3'd3;
            W_PRST_HI: return pll_rst === 1'b1;
            default:   return pll_rst === 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget);
        int n;
        n = 0;
        total++;
        while (!cond(which)) begin
            @(posedge refclk); #1;
            n++;
            if (n > budget) begin
                bad++;
                $display("FAIL wait%0d: got timeout after %0d cycles, want condition met", which, budget);
                return;
            end
        end
    endtask

    // From RUN: drop the lock 3 cycles in; loss reaches outputs 3 cycles later.
    task automatic lose_lock(input logic [7:0] rc, input bit with_restart);
        wait_for(W_READY, 100);
        push(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, rc, 6);
        repeat (3) @(posedge refclk);
        #1 pll_locked = 1'b0;
        if (with_restart) begin
            repeat (2) @(posedge refclk);
            #1 restart = 1'b1;
            @(posedge refclk);
            #1 restart = 1'b0;
        end
    endtask

    // Raise lock 5 cycles after pll_rst falls (optionally with a 1-cycle glitch).
    task automatic bring_up(input logic [7:0] rc, input int wait_gap, input bit glitch);
        push(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, rc, wait_gap);
        push(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, rc, 8);
        if (glitch) begin
            push(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, rc, 5);
            push(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, rc, 1);
        end
        push(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, rc, 8);
        push(3'd3, 1'b0, 3'b100, 1'b0, 1'b0, rc, 2);
        push(3'd3, 1'b0, 3'b000, 1'b0, 1'b0, rc, 2);
        push(3'd4, 1'b0, 3'b000, 1'b1, 1'b0, rc, 1);
        wait_for(W_PRST_HI, 100);
        wait_for(W_PRST_LO, 100);
        repeat (5) @(posedge refclk);
        #1 pll_locked = 1'b1;
        if (glitch) begin
            repeat (5) @(posedge refclk);
            #1 pll_locked = 1'b0;
            @(posedge refclk);
            #1 pll_locked = 1'b1;
        end
    endtask

    // Monitor: every change of the output snapshot consumes one expectation.
    initial begin : monitor
        snap_t cur, prev;
        exp_t  e;
        int    cyc, last, nsnap;
        prev = 'x; cyc = 0; last = 0; nsnap = 0;
        forever begin
            @(negedge refclk);
            cyc++;
            cur = {state_o, pll_rst, domain_rst, ready, fail, relock_count};
            if (cur !== prev) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change@%0d: got st=%0d dom=%b rc=%0d, want no change", cyc, cur.st, cur.dom, cur.rc);
                end else begin
                    e = q.pop_front();
                    if (cur !== e.s) begin
                        bad++;
                        $display("FAIL snap%0d: got st=%0d prst=%b dom=%b rdy=%b fail=%b rc=%0d, want st=%0d prst=%b dom=%b rdy=%b fail=%b rc=%0d",
                                 nsnap, cur.st, cur.prst, cur.dom, cur.rdy, cur.fl, cur.rc,
                                 e.s.st, e.s.prst, e.s.dom, e.s.rdy, e.s.fl, e.s.rc);
                    end
                    if (e.gap >= 0) begin
                        total++;
                        if (cyc - last != e.gap) begin
                            bad++;
                            $display("FAIL gap%0d: got %0d cycles, want %0d", nsnap, cyc - last, e.gap);
                        end
                    end
                end
                nsnap++;
                prev = cur;
                last = cyc;
            end
        end
    end

    initial begin : watchdog
        repeat (40000) @(posedge refclk);
        $display("FAIL watchdog: got no completion in 40000 cycles, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] rc;
        rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
        push(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, -1);
        repeat (3) @(posedge refclk);
        #1 rst = 1'b0;

        // Normal bring-up: pll_rst high 4 cycles after rst release (+2 reset cycles).
        bring_up(8'd0, 6, 1'b0);

        // Lock loss in RUN, resequence with a lock glitch in WAIT_LOCK.
        lose_lock(8'd1, 1'b0);
        bring_up(8'd1, 4, 1'b1);

        // Lock loss then no lock at all: two timed-out attempts, then FAIL.
        lose_lock(8'd2, 1'b0);
        push(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2, 4);
        push(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2, 32);
        push(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2, 4);
        push(3'd5, 1'b1, 3'b111, 1'b0, 1'b1, 8'd2, 32);
        wait_for(W_FAIL, 200);

        // Hold in FAIL 120 cycles, then restart; retries must be cleared.
        push(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2, 121);
        repeat (120) @(posedge refclk);
        #1 restart = 1'b1;
        @(posedge refclk);
        #1 restart = 1'b0;
        push(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd2, 4);
        push(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd2, 32);
        wait_for(W_PRST_LO, 100);
        bring_up(8'd2, 4, 1'b0);

        // restart coincident with lock loss in RUN: relock_count unchanged.
        lose_lock(8'd2, 1'b1);
        bring_up(8'd2, 4, 1'b0);

        // Drive relock_count into saturation.
        for (int i = 0; i < 256; i++) begin
            rc = (3 + i > 255) ? 8'd255 : 8'(3 + i);
            lose_lock(rc, 1'b0);
            bring_up(rc, 4, 1'b0);
        end

        // One more loss, then rst in the second RELEASE cycle.
        lose_lock(8'd255, 1'b0);
        push(3'd1, 1'b0, 3'b111, 1'b0, 1'b0, 8'd255, 4);
        push(3'd2, 1'b0, 3'b111, 1'b0, 1'b0, 8'd255, 8);
        push(3'd3, 1'b0, 3'b110, 1'b0, 1'b0, 8'd255, 8);
        push(3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 8'd0, 2);
        wait_for(W_PRST_HI, 100);
        wait_for(W_PRST_LO, 100);
        repeat (5) @(posedge refclk);
        #1 pll_locked = 1'b1;
        wait_for(W_REL, 100);
        @(posedge refclk);
        #1 rst = 1'b1;
        repeat (4) @(posedge refclk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d unconsumed expectations, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Controller for the video/system PLL: drives the PLL reset, qualifies its lock output, and sequences resets for the three output-clock domains (outclk_0..2).
- Retries failed locks and recovers from lock loss.
- Sits between the top-level reset and the PLL instance.
- Runs on the 50 MHz PLL reference clock.

Parameters:
- RST_PULSE_CYCLES, 16, cycles pll_rst is held high per reset attempt (min 1).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release.
- LOCK_TIMEOUT_CYCLES, 50000, max cycles in WAIT_LOCK before an attempt fails (1 ms at 50 MHz).
- MAX_RETRIES, 3, failed attempts allowed before FAIL.
- RELEASE_GAP, 8, cycles between successive domain reset releases.
- SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2).

Ports:
- refclk  in  1  clock (PLL reference clock).
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock output; asynchronous, synchronized internally.
- restart  in  1  single-cycle request to resequence the PLL from any state.
- pll_rst  out  1  reset to the PLL.
- domain_rst  out  3  active-high resets for the outclk_0..2 domains; each domain re-synchronizes its bit locally.
- ready  out  1  all domains released, PLL locked.
- fail  out  1  retries exhausted.
- relock_count  out  8  saturating count of lock losses seen in RUN.
- state_o  out  3  current state encoding for debug.

Behaviour:
- Clock and reset: one clock, refclk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state RESET_PLL, pll_rst=1, domain_rst=3'b111, ready=0, fail=0, relock_count=0. Retry and timer counters are 0.
- Lock input: locked_s is pll_locked after SYNC_STAGES flops. All decisions use locked_s only.
- State encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5. No other values.
- RESET_PLL: pll_rst=1 and domain_rst=111. Stay exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK with the timer cleared.
- WAIT_LOCK: pll_rst=0. The timer increments each cycle.
  - locked_s=1: go to STABLE with the stable counter at 0.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 with locked_s=0: increment retries. If retries now equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
  - If lock and timeout fall in the same cycle, lock wins.
- STABLE: the stable counter increments while locked_s=1.
  - locked_s=0 in any cycle: go to WAIT_LOCK with the timer cleared. This does not count as a retry.
  - Counter reaches LOCK_STABLE_CYCLES-1: go to RELEASE with the gap counter at 0.
- RELEASE: domain_rst[0] clears on the first RELEASE cycle, domain_rst[1] RELEASE_GAP cycles later, domain_rst[2] 2*RELEASE_GAP cycles later.
  - The cycle after domain_rst[2] clears: go to RUN, set ready=1, clear retries.
  - locked_s=0 during RELEASE is treated as a RUN lock loss (see below).
- RUN: ready=1, domain_rst=000.
  - locked_s=0: next cycle domain_rst=111 and ready=0; relock_count increments, saturating at 255; go to RESET_PLL.
- FAIL: pll_rst=1, domain_rst=111, fail=1. Stay here until restart or rst.
- restart (any state): next state RESET_PLL, retries cleared, fail=0, ready=0, domain_rst=111.
  - restart has priority over every other transition in the same cycle.
  - A lock loss coinciding with restart does not increment relock_count.
  - restart during RESET_PLL restarts the pulse counter.
- rst mid-operation: returns to the reset values above on the next edge, including relock_count=0.
- Latency: lock loss at the pll_locked pin to domain_rst=111 is at most SYNC_STAGES+1 cycles.

Test Plan (bench params RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, RELEASE_GAP=2, SYNC_STAGES=2):
1. Normal bring-up: deassert rst, raise pll_locked 5 cycles after pll_rst falls and hold it.
   - pll_rst high exactly 4 cycles.
   - STABLE entered 3 cycles after the pll_locked rise.
   - domain_rst goes 111→110→100→000 at 2-cycle spacing.
   - ready=1 one cycle after 000; relock_count=0.
2. Lock glitch: pll_locked high 5 cycles, low 1 cycle, then high.
   - state_o returns 2→1→2.
   - Release starts only after 8 uninterrupted locked cycles; fail=0.
3. Timeout: pll_locked held at 0.
   - Two pll_rst pulses of 4 cycles, each followed by a 32-cycle WAIT_LOCK.
   - Then state_o=5, fail=1, pll_rst=1 held for 100+ cycles.
4. Lock loss in RUN: drop pll_locked.
   - domain_rst=111 and ready=0 within 3 cycles; relock_count 0→1.
   - Full resequence completes and ready returns to 1.
5. restart in FAIL, and restart coincident with lock loss in RUN:
   - In FAIL: fail clears next cycle, state_o=0.
   - Coincident case: relock_count is unchanged.
6. Saturation and rst: force 256 lock losses, then assert rst mid-RELEASE.
   - relock_count stops at 255.
   - After rst: relock_count=0, domain_rst=111, pll_rst=1, state_o=0.
